rf_wport_arb: RTL
=================

RF_WPORT_ARB -- requirements
Module: rf_wport_arb

Interface
REQ-001 SHALL have parameter STARVE_LIM, default 8, meaning the number of consecutive cycles a queued multiply/divide result may wait before stall is requested (range 1..15).
REQ-002 SHALL have clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have rst_n  input  1  synchronous, active-high reset (asserted = 1).
REQ-004 SHALL have wb_we / wb_addr / wb_data  input  1/5/32  pipeline writeback request, address, and data (load-extracted or ALU result).
REQ-005 SHALL have md_valid / md_addr / md_data  input  1/5/32  multiply/divide unit result offer.
REQ-006 SHALL have md_ready  output  1  queue can accept an md result this cycle.
REQ-007 SHALL have id_rs / id_rt  input  5/5  decode-stage source register numbers.
REQ-008 SHALL have pend_hit  output  1  a live queued md result targets nonzero id_rs or id_rt.
REQ-009 SHALL have stall_req  output  1  request to bubble the pipeline writeback slot.
REQ-010 SHALL have rf_we / rf_waddr / rf_wdata  output  1/5/32  single register-file write port.

Function
REQ-011 SHALL hold a 2-entry in-order FIFO of {addr, data, live}, plus a 2-bit count and a 4-bit wait counter.
REQ-012 SHALL treat a write to register 0 (wb_addr or md_addr == 0) as no write: a WB request is ignored, and an md offer is accepted but never enqueued.
REQ-013 SHALL give the pipeline priority: when wb_we=1 and wb_addr!=0, rf_we=1 with rf_waddr/rf_wdata = wb_addr/wb_data, combinationally.
REQ-014 SHALL drain the FIFO head when the port is free (no effective WB write): rf_we = head.live, the head's addr/data are driven, and the head is popped at the clock edge.
REQ-015 SHALL drive md_ready = (count < 2) from registered state only; a same-cycle pop does not raise md_ready.
REQ-016 SHALL enqueue on md_valid & md_ready with live=1; a simultaneous push and pop keeps count unchanged and preserves order.
REQ-017 SHALL clear the live bit of every queued entry whose addr equals an effective WB write address in the same cycle; a killed entry still occupies its slot and pops without writing.
REQ-018 SHALL NOT kill an md result being enqueued in the same cycle as a WB write to the same address.
REQ-019 SHALL drive pend_hit = OR over valid, live entries of (addr==id_rs & id_rs!=0) | (addr==id_rt & id_rt!=0), combinationally.
REQ-020 SHALL run the wait counter as follows: it increments each cycle the FIFO is non-empty and the head is not popped, saturating at 15, and clears on pop or when the FIFO is empty.
REQ-021 SHALL register stall_req = 1 on the edge where the wait counter reaches STARVE_LIM, and clear it on the edge the head pops.
REQ-022 SHALL assume the pipeline holds wb_we=0 one cycle after stall_req rises; if wb_we is nonetheless 1, WB still wins.

Reset
REQ-023 SHALL, while rst_n=1 at a clock edge, set count=0, all live=0, wait counter=0, and stall_req=0.
REQ-024 SHALL force rf_we=0, md_ready=0, and pend_hit=0 combinationally while rst_n=1; any queued results are discarded, including on reset mid-drain.
REQ-025 SHALL drive md_ready=1 and rf_we=0 in the first cycle after reset deasserts, with no WB or md activity.

Configuration
REQ-026 SHALL, when MD_BYPASS_EN is defined, write an md offer straight to the port in the same cycle if the FIFO is empty, the port is free, md_valid=1, and md_addr!=0; md_ready=1 in that cycle and nothing is enqueued.
REQ-027 SHALL, when MD_BYPASS_EN is undefined, route every md result through the FIFO (minimum 1-cycle latency from accept to rf_we).

Verification
REQ-028 SHALL cover idle drain: md_valid=1, md_addr=5, md_data=0x1234 accepted with wb_we=0 -> next cycle rf_we=1, waddr=5, wdata=0x1234 (same cycle if MD_BYPASS_EN).
REQ-029 SHALL cover priority and fill: wb_we=1 held while 3 md results are offered -> first two accepted, md_ready=0 on the third, rf port shows only WB writes.
REQ-030 SHALL cover the kill rule: queued entry addr=7, then WB writes r7=0xAAAA -> the entry later pops with rf_we=0, and the final r7 is 0xAAAA.
REQ-031 SHALL cover starvation: one entry queued and wb_we=1 continuously with STARVE_LIM=8 -> stall_req=1 after 8 waiting cycles; drop wb_we -> the entry is written and stall_req=0 the next cycle.
REQ-032 SHALL cover hazard and r0: queued addr=3 with id_rt=3 -> pend_hit=1; md_addr=0 accepted -> count unchanged, no write.
REQ-033 SHALL cover reset mid-drain: two entries queued, rst_n=1 for one cycle -> count=0, no rf write, and stall_req=0 afterwards.

Source files
------------

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: pipeline writeback wins; multiply/divide results queue in a
// 2-entry FIFO and drain on free cycles. Define MD_BYPASS_EN for same-cycle md write when idle.
module rf_wport_arb #(
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  output logic        pend_hit,
  output logic        stall_req,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  logic [1:0][4:0]  addr_q, addr_d;
  logic [1:0][31:0] data_q, data_d;
  logic [1:0]       live_q, live_d, live_k;
  logic [1:0]       count_q, count_d;
  logic [3:0]       wait_q, wait_d;
  logic             stall_q, stall_d;

  logic wb_eff, empty, pop, push, bypass;

  assign wb_eff = wb_we & (wb_addr != 5'd0) & ~rst_n;
  assign empty  = (count_q == 2'd0);
  // md_ready looks only at registered occupancy, so a same-cycle pop never widens it.
  assign md_ready = ~rst_n & (count_q < 2'd2);
  assign pop      = ~rst_n & ~empty & ~wb_eff;

`ifdef MD_BYPASS_EN
  assign bypass = ~rst_n & empty & ~wb_eff & md_valid & (md_addr != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  assign push = md_valid & md_ready & (md_addr != 5'd0) & ~bypass;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      live_k[i] = live_q[i] & ~(wb_eff & (addr_q[i] == wb_addr));
    end

    addr_d  = addr_q;
    data_d  = data_q;
    live_d  = live_k;
    count_d = count_q;

    if (pop) begin
      addr_d[0] = addr_q[1];
      data_d[0] = data_q[1];
      live_d[0] = live_k[1];
      live_d[1] = 1'b0;
      count_d   = count_q - 2'd1;
    end

    // The entry being pushed is written after the kill, so a same-address WB cannot kill it.
    if (push) begin
      addr_d[count_d[0]] = md_addr;
      data_d[count_d[0]] = md_data;
      live_d[count_d[0]] = 1'b1;
      count_d            = count_d + 2'd1;
    end

    if (empty || pop) begin
      wait_d = 4'd0;
    end else if (wait_q == 4'd15) begin
      wait_d = 4'd15;
    end else begin
      wait_d = wait_q + 4'd1;
    end

    if (pop) begin
      stall_d = 1'b0;
    end else if (wait_d == 4'(STARVE_LIM)) begin
      stall_d = 1'b1;
    end else begin
      stall_d = stall_q;
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = addr_q[0];
    rf_wdata = data_q[0];
    if (wb_eff) begin
      rf_we    = 1'b1;
      rf_waddr = wb_addr;
      rf_wdata = wb_data;
    end else if (bypass) begin
      rf_we    = 1'b1;
      rf_waddr = md_addr;
      rf_wdata = md_data;
    end else if (pop) begin
      rf_we = live_q[0];
    end
  end

  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n && (count_q > 2'(i)) && live_q[i]) begin
        if (((addr_q[i] == id_rs) && (id_rs != 5'd0)) ||
            ((addr_q[i] == id_rt) && (id_rt != 5'd0))) begin
          pend_hit = 1'b1;
        end
      end
    end
  end

  assign stall_req = stall_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      live_q  <= '0;
      count_q <= 2'd0;
      wait_q  <= 4'd0;
      stall_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      live_q  <= live_d;
      count_q <= count_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

endmodule
